// File: rtl/fetch_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_branch_ctrl
// Purpose  : Fetch/issue sequencer with conditional branches, subroutine
//            return stack and single-level interrupt entry/exit.
//            Optional macro FBC_NEG_COND_EN enables BMI/BPL branch conditions.
// Revision : 1.0  initial release
// ============================================================================
module fetch_branch_ctrl #(
    parameter int AW       = 8,
    parameter int IW       = 8,
    parameter int DW       = 8,
    parameter int MW       = 4,
    parameter int RS_DEPTH = 4,
    parameter int BR_WAIT  = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [IW-1:0] instr,
    input  logic [DW-1:0] data_in,
    input  logic          fetch_ack,
    input  logic          i_pending,
    input  logic [AW-1:0] i_vector,
    input  logic          ccr_z,
    input  logic          ccr_n,
    input  logic          stg1_ready,
    output logic          fetch_req,
    output logic [AW-1:0] pc_out,
    output logic          stg0_valid,
    output logic [IW-1:0] stg0_instr,
    output logic          itr_ack,
    output logic          in_itr,
    output logic [MW-1:0] itr_mask,
    output logic          rs_err,
    output logic [3:0]    state
);

    localparam int c_RSW = $clog2(RS_DEPTH);
    localparam int c_CW  = $clog2(BR_WAIT + 1);

    localparam logic [4:0] c_OP_BRA  = 5'b00110;
    localparam logic [4:0] c_OP_JMP  = 5'b00111;
    localparam logic [4:0] c_OP_RTS  = 5'b01000;
    localparam logic [4:0] c_OP_RTI  = 5'b01001;
    localparam logic [4:0] c_OP_LMSK = 5'b01110;
    localparam logic [4:0] c_OP_BSR  = 5'b10101;

    localparam logic [c_RSW:0]   c_RS_FULL = (c_RSW + 1)'(RS_DEPTH);
    localparam logic [c_CW-1:0]  c_BR_LOAD = c_CW'(BR_WAIT);
    localparam logic [c_CW-1:0]  c_BR_ONE  = c_CW'(1);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_ITR     = 4'd2,
        S_DECODE  = 4'd3,
        S_ISSUE   = 4'd4,
        S_BR_EVAL = 4'd5,
        S_CALL    = 4'd6,
        S_JUMP    = 4'd7,
        S_RET     = 4'd8,
        S_MASK    = 4'd9
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     pc_q;
    logic              fetch_req_q;
    logic              stg0_valid_q;
    logic [IW-1:0]     stg0_instr_q;
    logic              itr_ack_q;
    logic              in_itr_q;
    logic [AW-1:0]     itr_ret_q;
    logic [MW-1:0]     itr_mask_q;
    logic              rs_err_q;
    logic [c_RSW-1:0]  rs_wp_q;
    logic [c_RSW:0]    rs_cnt_q;
    logic [c_CW-1:0]   br_cnt_q;
    logic [AW-1:0]     rs_mem_q [RS_DEPTH];

    logic [4:0]        w_opcode;
    logic [2:0]        w_cond;
    logic [c_RSW-1:0]  w_rs_top;
    logic              w_br_taken;
    logic              w_unused;

    assign w_opcode = stg0_instr_q[IW-1:IW-5];
    assign w_cond   = stg0_instr_q[2:0];
    assign w_rs_top = rs_wp_q - c_RSW'(1);
    assign w_unused = ^{ccr_n, data_in};

    always_comb begin
        w_br_taken = 1'b0;
        case (w_cond)
            3'b000:  w_br_taken = ccr_z;
            3'b001:  w_br_taken = ~ccr_z;
`ifdef FBC_NEG_COND_EN
            3'b010:  w_br_taken = ccr_n;
            3'b011:  w_br_taken = ~ccr_n;
`else
`endif
            default: w_br_taken = 1'b0;
        endcase
    end

    // Return-stack storage; the write pointer wraps so a full push replaces the oldest entry.
    always_ff @(posedge clk) begin
        if (state_q == S_CALL) begin
            rs_mem_q[rs_wp_q] <= pc_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_INIT;
            pc_q         <= '0;
            fetch_req_q  <= 1'b0;
            stg0_valid_q <= 1'b0;
            stg0_instr_q <= '0;
            itr_ack_q    <= 1'b0;
            in_itr_q     <= 1'b0;
            itr_ret_q    <= '0;
            itr_mask_q   <= '0;
            rs_err_q     <= 1'b0;
            rs_wp_q      <= '0;
            rs_cnt_q     <= '0;
            br_cnt_q     <= '0;
        end else begin
            itr_ack_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_pending && !in_itr_q) begin
                        fetch_req_q <= 1'b0;
                        itr_ack_q   <= 1'b1;
                        state_q     <= S_ITR;
                    end else if (fetch_req_q && fetch_ack) begin
                        fetch_req_q  <= 1'b0;
                        stg0_instr_q <= instr;
                        pc_q         <= pc_q + AW'(1);
                        state_q      <= S_DECODE;
                    end else begin
                        fetch_req_q <= 1'b1;
                    end
                end
                S_ITR: begin
                    itr_ret_q <= pc_q;
                    pc_q      <= i_vector;
                    in_itr_q  <= 1'b1;
                    state_q   <= S_FETCH;
                end
                S_DECODE: begin
                    case (w_opcode)
                        c_OP_BSR: state_q <= S_CALL;
                        c_OP_RTS,
                        c_OP_RTI: state_q <= S_RET;
                        default: begin
                            stg0_valid_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
                    endcase
                end
                S_CALL: begin
                    rs_wp_q <= rs_wp_q + c_RSW'(1);
                    if (rs_cnt_q == c_RS_FULL) begin
                        rs_err_q <= 1'b1;
                    end else begin
                        rs_cnt_q <= rs_cnt_q + (c_RSW + 1)'(1);
                    end
                    stg0_valid_q <= 1'b1;
                    state_q      <= S_ISSUE;
                end
                S_RET: begin
                    if (w_opcode == c_OP_RTI) begin
                        pc_q     <= itr_ret_q;
                        in_itr_q <= 1'b0;
                    end else if (rs_cnt_q == '0) begin
                        pc_q     <= '0;
                        rs_err_q <= 1'b1;
                    end else begin
                        pc_q     <= rs_mem_q[w_rs_top];
                        rs_wp_q  <= w_rs_top;
                        rs_cnt_q <= rs_cnt_q - (c_RSW + 1)'(1);
                    end
                    stg0_valid_q <= 1'b1;
                    state_q      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (stg1_ready) begin
                        stg0_valid_q <= 1'b0;
                        case (w_opcode)
                            c_OP_BRA: begin
                                br_cnt_q <= c_BR_LOAD;
                                state_q  <= S_BR_EVAL;
                            end
                            // BSR reaches its target through the same path as JMP.
                            c_OP_JMP,
                            c_OP_BSR:  state_q <= S_JUMP;
                            c_OP_LMSK: state_q <= S_MASK;
                            default:   state_q <= S_FETCH;
                        endcase
                    end
                end
                S_BR_EVAL: begin
                    br_cnt_q <= br_cnt_q - c_BR_ONE;
                    if (br_cnt_q == c_BR_ONE) begin
                        state_q <= w_br_taken ? S_JUMP : S_FETCH;
                    end
                end
                S_JUMP: begin
                    pc_q    <= data_in[AW-1:0];
                    state_q <= S_FETCH;
                end
                S_MASK: begin
                    itr_mask_q <= data_in[MW-1:0];
                    state_q    <= S_FETCH;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign fetch_req  = fetch_req_q;
    assign pc_out     = pc_q;
    assign stg0_valid = stg0_valid_q;
    assign stg0_instr = stg0_instr_q;
    assign itr_ack    = itr_ack_q;
    assign in_itr     = in_itr_q;
    assign itr_mask   = itr_mask_q;
    assign rs_err     = rs_err_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_branch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_branch_ctrl
// Purpose  : Directed and randomized checks of fetch_branch_ctrl against an
//            instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_branch_ctrl;

    localparam int AW = 8, IW = 8, DW = 8, MW = 4, RS_DEPTH = 4, BR_WAIT = 2;

`ifdef FBC_NEG_COND_EN
    localparam bit c_NEG_EN = 1'b1;
`else
    localparam bit c_NEG_EN = 1'b0;
`endif

    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_BRA  = 5'b00110;
    localparam logic [4:0] c_OP_JMP  = 5'b00111;
    localparam logic [4:0] c_OP_RTS  = 5'b01000;
    localparam logic [4:0] c_OP_RTI  = 5'b01001;
    localparam logic [4:0] c_OP_LMSK = 5'b01110;
    localparam logic [4:0] c_OP_BSR  = 5'b10101;

    logic          clk = 1'b0;
    logic          clr;
    logic [IW-1:0] instr;
    logic [DW-1:0] data_in;
    logic          fetch_ack, i_pending, ccr_z, ccr_n, stg1_ready;
    logic [AW-1:0] i_vector;
    logic          fetch_req, stg0_valid, itr_ack, in_itr, rs_err;
    logic [AW-1:0] pc_out;
    logic [IW-1:0] stg0_instr;
    logic [MW-1:0] itr_mask;
    logic [3:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] other_ops [6] = '{5'b00000, 5'b00001, 5'b00101, 5'b01111, 5'b10000, 5'b11111};

    // Reference model: architectural state after each accepted instruction.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_itr_ret;
    logic [MW-1:0] m_mask;
    logic          m_rs_err;
    logic          m_in_itr;
    logic [AW-1:0] m_stack [$];

    always #5 clk = ~clk;

    fetch_branch_ctrl #(
        .AW(AW), .IW(IW), .DW(DW), .MW(MW), .RS_DEPTH(RS_DEPTH), .BR_WAIT(BR_WAIT)
    ) u_dut (
        .clk        (clk),
        .clr        (clr),
        .instr      (instr),
        .data_in    (data_in),
        .fetch_ack  (fetch_ack),
        .i_pending  (i_pending),
        .i_vector   (i_vector),
        .ccr_z      (ccr_z),
        .ccr_n      (ccr_n),
        .stg1_ready (stg1_ready),
        .fetch_req  (fetch_req),
        .pc_out     (pc_out),
        .stg0_valid (stg0_valid),
        .stg0_instr (stg0_instr),
        .itr_ack    (itr_ack),
        .in_itr     (in_itr),
        .itr_mask   (itr_mask),
        .rs_err     (rs_err),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},        32'(pc_out),     32'd0);
        check({tag, "_fetch_req"}, 32'(fetch_req),  32'd0);
        check({tag, "_valid"},     32'(stg0_valid), 32'd0);
        check({tag, "_instr"},     32'(stg0_instr), 32'd0);
        check({tag, "_itr_ack"},   32'(itr_ack),    32'd0);
        check({tag, "_in_itr"},    32'(in_itr),     32'd0);
        check({tag, "_mask"},      32'(itr_mask),   32'd0);
        check({tag, "_rs_err"},    32'(rs_err),     32'd0);
    endtask

    task automatic wait_req(input string tag, output int lat);
        lat = 0;
        while (!fetch_req && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!fetch_req) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic bit br_taken(input logic [2:0] c, input logic z, input logic n);
        return (c == 3'd0 && z) || (c == 3'd1 && !z) ||
               (c_NEG_EN && c == 3'd2 && n) || (c_NEG_EN && c == 3'd3 && !n);
    endfunction

    function automatic logic [IW-1:0] gen_instr(input bit allow_rti);
        logic [4:0] op;
        logic [2:0] cc;
        int k;
        k  = $urandom_range(0, 11);
        cc = 3'($urandom_range(0, 7));
        case (k)
            0, 1, 2: op = c_OP_BRA;
            3:       op = c_OP_JMP;
            4, 5:    op = c_OP_BSR;
            6:       op = c_OP_RTS;
            7:       op = allow_rti ? c_OP_RTI : c_OP_RTS;
            8:       op = c_OP_LMSK;
            default: op = other_ops[$urandom_range(0, 5)];
        endcase
        return {op, cc};
    endfunction

    task automatic model_exec(input logic [IW-1:0] ins, input logic [DW-1:0] d,
                              input logic z, input logic n);
        logic [4:0] op;
        op   = ins[IW-1:IW-5];
        m_pc = m_pc + 8'd1;
        if (op == c_OP_BSR) begin
            if (m_stack.size() == RS_DEPTH) begin
                void'(m_stack.pop_front());
                m_rs_err = 1'b1;
            end
            m_stack.push_back(m_pc);
            m_pc = d[AW-1:0];
        end else if (op == c_OP_RTS) begin
            if (m_stack.size() == 0) begin
                m_pc     = '0;
                m_rs_err = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (op == c_OP_RTI) begin
            m_pc     = m_itr_ret;
            m_in_itr = 1'b0;
        end else if (op == c_OP_JMP) begin
            m_pc = d[AW-1:0];
        end else if (op == c_OP_LMSK) begin
            m_mask = d[MW-1:0];
        end else if (op == c_OP_BRA && br_taken(ins[2:0], z, n)) begin
            m_pc = d[AW-1:0];
        end
    endtask

    initial begin
        int lat, nvalid, idle, n_fetch;
        bit seen, exp_ack, was_itr;
        logic [IW-1:0] cur_instr, last_instr;

        clr = 1'b1; instr = '0; data_in = '0; fetch_ack = 1'b0; i_pending = 1'b0;
        i_vector = '0; ccr_z = 1'b0; ccr_n = 1'b0; stg1_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        clr = 1'b0;
        @(negedge clk); check("req_edge1", 32'(fetch_req), 32'd0);
        @(negedge clk); check("req_edge2", 32'(fetch_req), 32'd1);

        // Plain instruction: minimum issue latency
        stg1_ready = 1'b1; instr = {c_OP_ADD, 3'b000}; fetch_ack = 1'b1;
        @(negedge clk); fetch_ack = 1'b0;
        check("add_pc", 32'(pc_out), 32'd1);
        check("add_instr", 32'(stg0_instr), 32'(8'b00000000));
        lat = 0; nvalid = 0;
        while (!fetch_req && lat < 20) begin
            nvalid += int'(stg0_valid);
            @(negedge clk);
            lat++;
        end
        check("add_lat", 32'(lat), 32'd3);
        check("add_valid_cycles", 32'(nvalid), 32'd1);

        // Load mask
        instr = {c_OP_LMSK, 3'b000}; data_in = 8'h0A; fetch_ack = 1'b1;
        @(negedge clk); fetch_ack = 1'b0;
        wait_req("lmsk", lat);
        check("lmsk_lat", 32'(lat), 32'd4);
        check("lmsk_mask", 32'(itr_mask), 32'hA);
        check("lmsk_pc", 32'(pc_out), 32'd2);

        // BEQ taken: target appears BR_WAIT+1 cycles after entering evaluation
        instr = {c_OP_BRA, 3'b000}; data_in = 8'h40; ccr_z = 1'b1; fetch_ack = 1'b1;
        @(negedge clk); fetch_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("beq_pc_hold", 32'(pc_out), 32'd3);
        @(negedge clk);
        check("beq_pc_target", 32'(pc_out), 32'h40);
        wait_req("beq", lat);

        // BNE (not taken) interrupted by an asynchronous clear while evaluating
        instr = {c_OP_BRA, 3'b001}; data_in = 8'h55; fetch_ack = 1'b1;
        @(negedge clk); fetch_ack = 1'b0;
        check("bne_pc", 32'(pc_out), 32'h41);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 clr = 1'b1;
        #1 check_reset("mid_clr");
        @(negedge clk); @(negedge clk);

        // Randomized run against the instruction-level model
        m_pc = '0; m_itr_ret = '0; m_mask = '0; m_rs_err = 1'b0; m_in_itr = 1'b0;
        m_stack.delete();
        seen = 1'b0; exp_ack = 1'b0; idle = 0; n_fetch = 0; last_instr = '0; cur_instr = '0;
        clr = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            check("itr_ack", 32'(itr_ack), 32'(exp_ack));
            exp_ack    = 1'b0;
            fetch_ack  = 1'b0;
            i_pending  = 1'b0;
            was_itr    = m_in_itr;
            stg1_ready = ($urandom_range(0, 3) != 0);
            if (stg0_valid && stg1_ready) check("issue_instr", 32'(stg0_instr), 32'(last_instr));
            if (fetch_req) begin
                idle = 0;
                if (!seen) begin
                    seen = 1'b1;
                    check("fetch_pc", 32'(pc_out), 32'(m_pc));
                    check("mask", 32'(itr_mask), 32'(m_mask));
                    check("rs_err", 32'(rs_err), 32'(m_rs_err));
                    check("in_itr", 32'(in_itr), 32'(m_in_itr));
                    cur_instr = gen_instr(m_in_itr);
                end
                if (!m_in_itr && $urandom_range(0, 9) == 0) begin
                    i_pending = 1'b1;
                    i_vector  = 8'($urandom);
                    exp_ack   = 1'b1;
                    m_itr_ret = m_pc;
                    m_pc      = i_vector;
                    m_in_itr  = 1'b1;
                    seen      = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    fetch_ack  = 1'b1;
                    instr      = cur_instr;
                    data_in    = 8'($urandom);
                    ccr_z      = 1'($urandom);
                    ccr_n      = 1'($urandom);
                    last_instr = cur_instr;
                    model_exec(cur_instr, data_in, ccr_z, ccr_n);
                    n_fetch++;
                    seen = 1'b0;
                end
            end else begin
                idle++;
            end
            // While an interrupt is being serviced further requests must be ignored.
            if (was_itr && !i_pending) i_pending = 1'($urandom);
            if (idle > 60) begin
                check("random_timeout", 32'd0, 32'd1);
                break;
            end
        end
        check("fetch_count_min", 32'(n_fetch >= 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_branch_ctrl.md
FETCH_BRANCH_CTRL -- requirements
Module: fetch_branch_ctrl

Interface
REQ-001 Parameter AW, default 8, PC/address width.
REQ-002 Parameter IW, default 8, instruction width; opcode = instr[IW-1:IW-5], condition = instr[2:0].
REQ-003 Parameter DW, default 8, operand (data_in) width, DW >= AW.
REQ-004 Parameter MW, default 4, interrupt mask width, MW <= DW.
REQ-005 Parameter RS_DEPTH, default 4, subroutine return-stack depth (power of 2, >= 2).
REQ-006 Parameter BR_WAIT, default 2, flag-settle cycles before branch evaluation (>= 1).
REQ-007 clk  in  1  system clock; all state changes on its rising edge.
REQ-008 clr  in  1  reset, asynchronous, active-high.
REQ-009 instr  in  IW  fetched instruction, valid when fetch_ack=1.
REQ-010 data_in  in  DW  operand from stage 1 (branch target / mask value).
REQ-011 fetch_ack  in  1  memory returns instr for current pc_out.
REQ-012 i_pending  in  1  pending interrupt request.
REQ-013 i_vector  in  AW  interrupt service address.
REQ-014 ccr_z, ccr_n  in  1 each  zero and negative condition flags.
REQ-015 stg1_ready  in  1  stage 1 handshake: accepts issued instruction.
REQ-016 fetch_req  out  1  request read at pc_out.
REQ-017 pc_out  out  AW  program counter.
REQ-018 stg0_valid  out  1  instruction issued to stage 1, held until stg1_ready.
REQ-019 stg0_instr  out  IW  registered instruction.
REQ-020 itr_ack  out  1  one-cycle interrupt acceptance pulse.
REQ-021 in_itr  out  1  servicing interrupt.
REQ-022 itr_mask  out  MW  interrupt mask register.
REQ-023 rs_err  out  1  sticky return-stack underflow/overflow flag.
REQ-024 state  out  4  encoded FSM state, for debug.

Function
REQ-025 States: INIT, FETCH, ITR, DECODE, ISSUE, BR_EVAL, CALL, JUMP, RET, MASK; INIT -> FETCH unconditionally.
REQ-026 FETCH: if i_pending=1 and in_itr=0 -> ITR (fetch_req=0); else fetch_req=1 until fetch_ack; on ack stg0_instr<=instr, pc_out<=pc_out+1 (modulo 2^AW), -> DECODE.
REQ-027 ITR (1 cycle): itr_ack=1, itr_ret<=pc_out, pc_out<=i_vector, in_itr<=1, -> FETCH; i_pending while in_itr=1 is ignored.
REQ-028 DECODE (1 cycle): BSR(10101) -> CALL; RTS(01000)/RTI(01001) -> RET; all others -> ISSUE.
REQ-029 ISSUE: stg0_valid=1; wait for stg1_ready; on ready: BRA(00110) -> BR_EVAL with counter<=BR_WAIT; JMP(00111) -> JUMP; LMSK(01110) -> MASK; else -> FETCH.
REQ-030 BR_EVAL: counter decrements each cycle; at counter=1 evaluate: 000 BEQ (ccr_z=1), 001 BNE (ccr_z=0); taken -> JUMP, else -> FETCH; other codes per REQ-041/042.
REQ-031 JUMP (1 cycle): pc_out<=data_in[AW-1:0], -> FETCH.
REQ-032 CALL (1 cycle): push pc_out onto return stack, -> ISSUE (target loaded via JMP path: ISSUE of BSR -> JUMP).
REQ-033 RET (1 cycle): RTS pops stack into pc_out; RTI loads itr_ret into pc_out and clears in_itr; -> ISSUE, then ISSUE -> FETCH.
REQ-034 MASK (1 cycle): itr_mask<=data_in[MW-1:0], -> FETCH.
REQ-035 Stack full push: overwrite oldest entry (circular), set rs_err; empty pop: pc_out<=0, set rs_err.
REQ-036 Minimum latency non-branch instruction: fetch_ack to next fetch_req = 3 cycles with stg1_ready held high.
REQ-037 fetch_ack outside FETCH, stg1_ready outside ISSUE: ignored.

Reset
REQ-038 clr=1 immediately forces state=INIT, pc_out=0, fetch_req=0, stg0_valid=0, stg0_instr=0, itr_ack=0, in_itr=0, itr_mask=0, rs_err=0, stack pointer empty, counter=0; applies mid-operation.
REQ-039 After clr deasserts, first fetch_req=1 occurs on the second rising edge.

Configuration
REQ-040 Macro FBC_NEG_COND_EN selects negative-flag branch conditions.
REQ-041 Defined: 010 BMI (ccr_n=1), 011 BPL (ccr_n=0) are evaluated as branches.
REQ-042 Undefined: ccr_n ignored; condition codes 010-111 never taken (-> FETCH).

Verification
REQ-043 Reset, instr ADD at pc 0, stg1_ready=1 -> pc_out=1, stg0_valid one cycle, fetch_req 3 cycles after ack.
REQ-044 BRA BEQ, data_in=0x40, ccr_z=1 -> pc_out=0x40 after BR_WAIT+1 cycles; ccr_z=0 -> pc_out unchanged, next fetch.
REQ-045 i_pending=1, i_vector=0x80 at pc 0x10 -> itr_ack pulse, pc_out=0x80, second i_pending ignored; RTI -> pc_out=0x10, in_itr=0.
REQ-046 Five nested BSR (RS_DEPTH=4) -> rs_err=1 on fifth push; five RTS -> rs_err remains 1, last pc_out=0.
REQ-047 LMSK data_in=0x0A -> itr_mask=0xA; clr pulse mid-BR_EVAL -> all outputs to REQ-038 values.
REQ-048 BMI with ccr_n=1, data_in=0x20 -> pc_out=0x20 with FBC_NEG_COND_EN, fall-through without.
